// File: rtl/sram_port_mux.sv
// Two-port time multiplexer for the single external 512 KB SRAM: port 1 is a
// read-only video fetch, port 2 is the CPU read/write port. Fixed 4-phase slots.
module sram_port_mux (
    input  logic        mclk,
    input  logic        rst,
    input  logic [18:0] a1,
    output logic [7:0]  dout1,
    output logic        dout1_stb,
    input  logic [18:0] a2,
    input  logic        we2_n,
    input  logic [7:0]  din2,
    output logic [7:0]  dout2,
    output logic        dout2_stb,
    output logic [18:0] sram_addr,
    inout  wire  [7:0]  sram_data,
    output logic        sram_we_n
);

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    logic [1:0] ph;
    logic [1:0] ph_next;

    // Port 2 slot registers, captured on entry to P2
    logic       slot_we_n_p2;
    logic [7:0] slot_din_p2;

    logic       drive_en;

    assign ph_next   = ph + 2'd1;
    assign sram_data = drive_en ? slot_din_p2 : 8'hzz;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            ph           <= P0;
            sram_addr    <= '0;
            sram_we_n    <= 1'b1;
            drive_en     <= 1'b0;
            dout1        <= 8'hFF;
            dout2        <= 8'hFF;
            dout1_stb    <= 1'b0;
            dout2_stb    <= 1'b0;
            slot_we_n_p2 <= 1'b1;
            slot_din_p2  <= '0;
        end else begin
            ph        <= ph_next;
            dout1_stb <= (ph_next == P2);
            dout2_stb <= (ph_next == P0);
            case (ph_next)
                // Video slot opens; the finished CPU slot delivers its byte
                P0: begin
                    sram_addr <= a1;
                    sram_we_n <= 1'b1;
                    drive_en  <= 1'b0;
                    dout2     <= slot_we_n_p2 ? sram_data : slot_din_p2;
                end
                // Access time for the video read spans P0 and P1
                P1: begin
                end
                // Video byte lands; CPU request is sampled and its address set up
                P2: begin
                    dout1        <= sram_data;
                    slot_we_n_p2 <= we2_n;
                    slot_din_p2  <= din2;
                    sram_addr    <= a2;
                    drive_en     <= ~we2_n;
                end
                // Write strobe, with address and data already stable for one mclk
                P3: begin
                    sram_we_n <= slot_we_n_p2;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_mux.sv
// Directed bench for sram_port_mux with a behavioural SRAM on the shared bus.
module tb_sram_port_mux;

    logic        mclk = 1'b0;
    logic        rst;
    logic [18:0] a1;
    logic [7:0]  dout1;
    logic        dout1_stb;
    logic [18:0] a2;
    logic        we2_n;
    logic [7:0]  din2;
    logic [7:0]  dout2;
    logic        dout2_stb;
    logic [18:0] sram_addr;
    wire  [7:0]  sram_data;
    logic        sram_we_n;

    logic [7:0]  mem [0:524287];
    logic        model_oe;
    int          n_checks = 0;
    int          n_pass   = 0;

    sram_port_mux dut (
        .mclk      (mclk),
        .rst       (rst),
        .a1        (a1),
        .dout1     (dout1),
        .dout1_stb (dout1_stb),
        .a2        (a2),
        .we2_n     (we2_n),
        .din2      (din2),
        .dout2     (dout2),
        .dout2_stb (dout2_stb),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_we_n (sram_we_n)
    );

    always #5 mclk = ~mclk;

    // SRAM: drives while WE is high (output gating lets writes be observed alone)
    assign sram_data = (sram_we_n && model_oe) ? mem[sram_addr] : 8'hzz;
    always @(posedge mclk) begin
        if (!sram_we_n)
            mem[sram_addr] = sram_data;
    end

    task automatic tick;
        @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic test_reset;
        rst = 1'b1; model_oe = 1'b1;
        a1 = 19'h2A000; a2 = 19'h05123; we2_n = 1'b1; din2 = 8'h00;
        mem[0] = 8'h5A; mem[19'h2A000] = 8'h3C; mem[19'h05123] = 8'hC3;
        repeat (2) @(negedge mclk);
        n_checks++;
        if (sram_we_n !== 1'b1 || sram_addr !== 19'h0)
            $display("FAIL reset_pins: we_n=%b addr=%h required we_n=1 addr=0", sram_we_n, sram_addr);
        else n_pass++;
        n_checks++;
        if (dout1 !== 8'hFF || dout2 !== 8'hFF || dout1_stb !== 1'b0 || dout2_stb !== 1'b0)
            $display("FAIL reset_outs: dout1=%h dout2=%h stb1=%b stb2=%b required FF FF 0 0", dout1, dout2, dout1_stb, dout2_stb);
        else n_pass++;
        rst = 1'b0;
        tick;
        n_checks++;
        if (sram_addr !== 19'h0 || dout1_stb !== 1'b0 || sram_we_n !== 1'b1)
            $display("FAIL first_edge: addr=%h stb1=%b we_n=%b required 0 0 1", sram_addr, dout1_stb, sram_we_n);
        else n_pass++;
        tick;
        n_checks++;
        if (dout1_stb !== 1'b1 || dout1 !== 8'h5A || sram_we_n !== 1'b1)
            $display("FAIL first_dout1_stb: stb1=%b dout1=%h we_n=%b required 1 5A 1", dout1_stb, dout1, sram_we_n);
        else n_pass++;
        tick;
        n_checks++;
        if (dout1_stb !== 1'b0 || sram_we_n !== 1'b1)
            $display("FAIL after_first_stb: stb1=%b we_n=%b required 0 1", dout1_stb, sram_we_n);
        else n_pass++;
        tick;
        n_checks++;
        if (dout2_stb !== 1'b1 || dout2 !== 8'hC3 || sram_addr !== 19'h2A000)
            $display("FAIL first_p0: stb2=%b dout2=%h addr=%h required 1 C3 2A000", dout2_stb, dout2, sram_addr);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        for (int r = 0; r < 3; r++) begin
            tick;
            n_checks++;
            if (sram_addr !== 19'h2A000 || dout1_stb !== 1'b0 || dout2_stb !== 1'b0 || sram_we_n !== 1'b1)
                $display("FAIL rr_p1[%0d]: addr=%h stb1=%b stb2=%b we_n=%b required 2A000 0 0 1", r, sram_addr, dout1_stb, dout2_stb, sram_we_n);
            else n_pass++;
            tick;
            n_checks++;
            if (dout1 !== 8'h3C || dout1_stb !== 1'b1 || dout2_stb !== 1'b0 || sram_addr !== 19'h05123)
                $display("FAIL rr_p2[%0d]: dout1=%h stb1=%b stb2=%b addr=%h required 3C 1 0 05123", r, dout1, dout1_stb, dout2_stb, sram_addr);
            else n_pass++;
            tick;
            n_checks++;
            if (dout1_stb !== 1'b0 || dout2_stb !== 1'b0 || sram_we_n !== 1'b1)
                $display("FAIL rr_p3[%0d]: stb1=%b stb2=%b we_n=%b required 0 0 1", r, dout1_stb, dout2_stb, sram_we_n);
            else n_pass++;
            tick;
            n_checks++;
            if (dout2 !== 8'hC3 || dout2_stb !== 1'b1 || dout1_stb !== 1'b0 || sram_addr !== 19'h2A000)
                $display("FAIL rr_p0[%0d]: dout2=%h stb2=%b stb1=%b addr=%h required C3 1 0 2A000", r, dout2, dout2_stb, dout1_stb, sram_addr);
            else n_pass++;
        end
    endtask

    task automatic test_write;
        // Starts in P0
        model_oe = 1'b0;
        a2 = 19'h48000; din2 = 8'hA5; we2_n = 1'b0; mem[19'h48000] = 8'h00;
        tick;
        n_checks++;
        if (sram_we_n !== 1'b1)
            $display("FAIL wr_p1_we: we_n=%b required 1", sram_we_n);
        else n_pass++;
        tick;
        we2_n = 1'b1; din2 = 8'h00;
        n_checks++;
        if (sram_addr !== 19'h48000 || sram_data !== 8'hA5 || sram_we_n !== 1'b1)
            $display("FAIL wr_p2: addr=%h bus=%h we_n=%b required 48000 A5 1", sram_addr, sram_data, sram_we_n);
        else n_pass++;
        tick;
        n_checks++;
        if (sram_we_n !== 1'b0 || sram_data !== 8'hA5 || sram_addr !== 19'h48000)
            $display("FAIL wr_p3: we_n=%b bus=%h addr=%h required 0 A5 48000", sram_we_n, sram_data, sram_addr);
        else n_pass++;
        tick;
        n_checks++;
        if (sram_we_n !== 1'b1 || dout2 !== 8'hA5 || dout2_stb !== 1'b1 || sram_addr !== 19'h2A000)
            $display("FAIL wr_p0: we_n=%b dout2=%h stb2=%b addr=%h required 1 A5 1 2A000", sram_we_n, dout2, dout2_stb, sram_addr);
        else n_pass++;
        n_checks++;
        if (mem[19'h48000] !== 8'hA5)
            $display("FAIL wr_mem: mem[48000]=%h required A5", mem[19'h48000]);
        else n_pass++;
        // Released bus lets the SRAM be read cleanly again
        model_oe = 1'b1;
        tick;
        tick;
        n_checks++;
        if (dout1 !== 8'h3C || dout1_stb !== 1'b1)
            $display("FAIL wr_release_dout1: dout1=%h stb1=%b required 3C 1", dout1, dout1_stb);
        else n_pass++;
        tick;
        n_checks++;
        if (sram_we_n !== 1'b1)
            $display("FAIL wr_once: we_n=%b required 1", sram_we_n);
        else n_pass++;
        tick;
        n_checks++;
        if (dout2 !== 8'hA5 || dout2_stb !== 1'b1)
            $display("FAIL wr_readback: dout2=%h stb2=%b required A5 1", dout2, dout2_stb);
        else n_pass++;
    endtask

    task automatic test_we_glitch;
        // Starts in P0; we2_n is low everywhere except across the P2 sample edge
        a2 = 19'h10000; din2 = 8'hEE; mem[19'h10000] = 8'h77;
        for (int s = 0; s < 2; s++) begin
            we2_n = 1'b0;
            tick;
            n_checks++;
            if (sram_we_n !== 1'b1)
                $display("FAIL glitch_p1[%0d]: we_n=%b required 1", s, sram_we_n);
            else n_pass++;
            we2_n = 1'b1;
            tick;
            we2_n = 1'b0;
            tick;
            n_checks++;
            if (sram_we_n !== 1'b1)
                $display("FAIL glitch_p3[%0d]: we_n=%b required 1", s, sram_we_n);
            else n_pass++;
            tick;
            n_checks++;
            if (dout2 !== 8'h77 || mem[19'h10000] !== 8'h77 || sram_we_n !== 1'b1)
                $display("FAIL glitch_p0[%0d]: dout2=%h mem=%h we_n=%b required 77 77 1", s, dout2, mem[19'h10000], sram_we_n);
            else n_pass++;
        end
        we2_n = 1'b1;
    endtask

    task automatic test_reset_mid_write;
        // Starts in P0
        a2 = 19'h48001; din2 = 8'h5C; we2_n = 1'b0; mem[19'h48001] = 8'h00;
        tick;
        tick;
        we2_n = 1'b1;
        tick;
        n_checks++;
        if (sram_we_n !== 1'b0)
            $display("FAIL mid_write_setup: we_n=%b required 0", sram_we_n);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (sram_we_n !== 1'b1 || sram_addr !== 19'h0)
            $display("FAIL async_reset_pins: we_n=%b addr=%h required 1 0", sram_we_n, sram_addr);
        else n_pass++;
        n_checks++;
        if (sram_data !== 8'h5A)
            $display("FAIL async_reset_bus: bus=%h required 5A (SRAM alone driving)", sram_data);
        else n_pass++;
        n_checks++;
        if (dout1 !== 8'hFF || dout2 !== 8'hFF)
            $display("FAIL async_reset_outs: dout1=%h dout2=%h required FF FF", dout1, dout2);
        else n_pass++;
        @(negedge mclk);
        rst = 1'b0;
        n_checks++;
        if (mem[19'h48001] !== 8'h00)
            $display("FAIL aborted_write: mem[48001]=%h required 00", mem[19'h48001]);
        else n_pass++;
        tick;
        n_checks++;
        if (sram_addr !== 19'h0 || dout1 !== 8'hFF || dout2 !== 8'hFF || sram_we_n !== 1'b1)
            $display("FAIL restart_p1: addr=%h dout1=%h dout2=%h we_n=%b required 0 FF FF 1", sram_addr, dout1, dout2, sram_we_n);
        else n_pass++;
        tick;
        n_checks++;
        if (dout1 !== 8'h5A || dout1_stb !== 1'b1)
            $display("FAIL restart_p2: dout1=%h stb1=%b required 5A 1", dout1, dout1_stb);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_write;
        test_we_glitch;
        test_reset_mid_write;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
